// File: rtl/key_debounce_if.sv
// Bundles the key pins, the press-count clear and the debounced outputs into one port.
// The slave modport is the debouncer's view; the master modport is whatever drives and watches it.
interface key_debounce_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_in;
    logic              count_clr;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [9:0]        press_count;

    modport master (
        output key_in,
        output count_clr,
        input  key_level,
        input  key_press,
        input  key_release,
        input  press_count
    );

    modport slave (
        input  key_in,
        input  count_clr,
        output key_level,
        output key_press,
        output key_release,
        output press_count
    );
endinterface

// File: rtl/key_debounce.sv
// Debounced key reader: synchronises raw key pins, filters contact bounce with a per-key
// stability counter, and reports clean levels, one-cycle edge pulses and a wrapping press count.
module key_debounce #(
    parameter int          N_KEYS     = 4,
    parameter logic [19:0] DEBOUNCE   = 20'd16,
    parameter logic        ACTIVE_LOW = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    key_debounce_if.slave bus
);

    logic [N_KEYS-1:0]       sync1_q;
    logic [N_KEYS-1:0]       sync2_q;
    logic [N_KEYS-1:0][19:0] cnt_q;
    logic [N_KEYS-1:0][19:0] cnt_d;
    logic [N_KEYS-1:0]       stable_q;
    logic [N_KEYS-1:0]       stable_d;
    logic [N_KEYS-1:0]       press_q;
    logic [N_KEYS-1:0]       press_d;
    logic [N_KEYS-1:0]       release_q;
    logic [N_KEYS-1:0]       release_d;
    logic [9:0]              count_q;
    logic [9:0]              count_d;
    logic [9:0]              pressSum;

    // Polarity is folded in ahead of the synchroniser so everything downstream sees 1 = pressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.key_in ^ {N_KEYS{ACTIVE_LOW}};
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        stable_d  = stable_q;
        press_d   = '0;
        release_d = '0;
        pressSum  = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            // A single cycle of agreement with the accepted state restarts the stability count.
            if (sync2_q[k] == stable_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == DEBOUNCE - 20'd1) begin
                cnt_d[k]     = '0;
                stable_d[k]  = sync2_q[k];
                press_d[k]   = sync2_q[k];
                release_d[k] = ~sync2_q[k];
            end else begin
                cnt_d[k] = cnt_q[k] + 20'd1;
            end
            pressSum = pressSum + 10'(press_d[k]);
        end
        count_d = bus.count_clr ? '0 : count_q + pressSum;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            count_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            count_q   <= count_d;
        end
    end

    assign bus.key_level   = stable_q;
    assign bus.key_press   = press_q;
    assign bus.key_release = release_q;
    assign bus.press_count = count_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus queues the expected pulse events, and a
// monitor per instance pops and compares them whenever that instance emits a pulse.
module tb_key_debounce;

    localparam int LAT = 18;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [9:0] count;
    } expEntry_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   nChecks = 0;
    int   nFails = 0;

    expEntry_t  qA[$];
    expEntry_t  qB[$];
    logic [3:0] expLevelA = '0;
    logic [3:0] expLevelB = '0;
    logic [9:0] expCountA = '0;
    logic [9:0] expCountB = '0;

    key_debounce_if #(.N_KEYS(4)) ifA ();
    key_debounce_if #(.N_KEYS(4)) ifB ();

    key_debounce #(.N_KEYS(4), .DEBOUNCE(20'd16), .ACTIVE_LOW(1'b0)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (ifA.slave)
    );

    key_debounce #(.N_KEYS(4), .DEBOUNCE(20'd16), .ACTIVE_LOW(1'b1)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (ifB.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // v is the logical pressed vector; instance B is active-low so its pins get ~v.
    task automatic applyStimulus(input bit useB, input logic [3:0] v);
        logic [3:0] prev;
        logic [3:0] pr;
        logic [3:0] rl;
        expEntry_t  e;
        prev = useB ? expLevelB : expLevelA;
        pr   = v & ~prev;
        rl   = ~v & prev;
        if (useB) begin
            ifB.key_in = ~v;
            expLevelB  = v;
            expCountB  = expCountB + 10'($countones(pr));
        end else begin
            ifA.key_in = v;
            expLevelA  = v;
            expCountA  = expCountA + 10'($countones(pr));
        end
        if ((pr | rl) != 4'b0000) begin
            e.cyc   = cyc + LAT;
            e.press = pr;
            e.rel   = rl;
            e.count = useB ? expCountB : expCountA;
            if (useB) qB.push_back(e);
            else      qA.push_back(e);
        end
    endtask

    task automatic scoreboardPop(input bit useB, input logic [3:0] pr, input logic [3:0] rl,
                                 input logic [9:0] cnt);
        expEntry_t e;
        string     tag;
        tag = useB ? "B" : "A";
        if ((useB && qB.size() == 0) || (!useB && qA.size() == 0)) begin
            checkOutput({tag, " unexpected pulse"}, 32'({pr, rl}), 0);
        end else begin
            e = useB ? qB.pop_front() : qA.pop_front();
            checkOutput({tag, " pulse cycle"}, cyc, e.cyc);
            checkOutput({tag, " key_press"}, 32'(pr), 32'(e.press));
            checkOutput({tag, " key_release"}, 32'(rl), 32'(e.rel));
            checkOutput({tag, " press_count"}, 32'(cnt), 32'(e.count));
        end
    endtask

    // Monitors: any pulse on an instance must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && ((ifA.key_press | ifA.key_release) != 4'b0000))
            scoreboardPop(1'b0, ifA.key_press, ifA.key_release, ifA.press_count);
    end

    always @(negedge clk) begin
        if (!reset && ((ifB.key_press | ifB.key_release) != 4'b0000))
            scoreboardPop(1'b1, ifB.key_press, ifB.key_release, ifB.press_count);
    end

    initial begin
        expEntry_t e;
        int        c;

        reset         = 1'b1;
        ifA.key_in    = 4'h0;
        ifA.count_clr = 1'b0;
        ifB.key_in    = 4'hF;
        ifB.count_clr = 1'b0;
        waitCycles(3);
        checkOutput("A reset key_level", 32'(ifA.key_level), 0);
        checkOutput("A reset key_press", 32'(ifA.key_press), 0);
        checkOutput("A reset key_release", 32'(ifA.key_release), 0);
        checkOutput("A reset press_count", 32'(ifA.press_count), 0);
        reset = 1'b0;
        waitCycles(5);

        // Clean press and release on key 0.
        applyStimulus(1'b0, 4'b0001);
        waitCycles(17);
        checkOutput("A0 level before accept", 32'(ifA.key_level[0]), 0);
        waitCycles(1);
        checkOutput("A0 level after accept", 32'(ifA.key_level[0]), 1);
        checkOutput("A count after press", 32'(ifA.press_count), 1);
        waitCycles(5);
        applyStimulus(1'b0, 4'b0000);
        waitCycles(17);
        checkOutput("A0 level before release", 32'(ifA.key_level[0]), 1);
        waitCycles(1);
        checkOutput("A0 level after release", 32'(ifA.key_level[0]), 0);
        checkOutput("A count after release", 32'(ifA.press_count), 1);
        waitCycles(5);

        // Bounce on key 1, then a solid press.
        for (int i = 0; i < 4; i++) begin
            ifA.key_in[1] = (i % 2 == 0);
            waitCycles(5);
        end
        checkOutput("A1 level during bounce", 32'(ifA.key_level), 0);
        applyStimulus(1'b0, 4'b0010);
        waitCycles(20);
        checkOutput("A1 level after bounce", 32'(ifA.key_level), 4'b0010);
        applyStimulus(1'b0, 4'b0000);
        waitCycles(20);

        // 15-cycle glitch on key 2 is rejected; 16 cycles is accepted.
        ifA.key_in[2] = 1'b1;
        waitCycles(15);
        ifA.key_in[2] = 1'b0;
        waitCycles(25);
        checkOutput("A2 level after glitch", 32'(ifA.key_level), 0);
        checkOutput("A count after glitch", 32'(ifA.press_count), 2);
        applyStimulus(1'b0, 4'b0100);
        waitCycles(16);
        applyStimulus(1'b0, 4'b0000);
        waitCycles(40);
        checkOutput("A count after 16-cycle pulse", 32'(ifA.press_count), 3);

        // All four keys together, then again with count_clr on the accept cycle.
        applyStimulus(1'b0, 4'hF);
        waitCycles(20);
        checkOutput("A count after 4 presses", 32'(ifA.press_count), 7);
        applyStimulus(1'b0, 4'h0);
        waitCycles(20);
        c          = cyc;
        ifA.key_in = 4'hF;
        e.cyc      = c + LAT;
        e.press    = 4'hF;
        e.rel      = 4'h0;
        e.count    = 10'd0;
        qA.push_back(e);
        expLevelA  = 4'hF;
        expCountA  = 10'd0;
        waitCycles(17);
        ifA.count_clr = 1'b1;
        waitCycles(1);
        ifA.count_clr = 1'b0;
        checkOutput("A count cleared with presses", 32'(ifA.press_count), 0);
        checkOutput("A level all pressed", 32'(ifA.key_level), 4'hF);
        applyStimulus(1'b0, 4'h0);
        waitCycles(20);

        // 1025 presses wrap the counter to 1, then count_clr zeroes it.
        for (int r = 0; r < 256; r++) begin
            applyStimulus(1'b0, 4'hF);
            waitCycles(20);
            applyStimulus(1'b0, 4'h0);
            waitCycles(20);
        end
        applyStimulus(1'b0, 4'b0001);
        waitCycles(20);
        checkOutput("A count after 1025 presses", 32'(ifA.press_count), 1);
        ifA.count_clr = 1'b1;
        waitCycles(1);
        ifA.count_clr = 1'b0;
        expCountA     = 10'd0;
        checkOutput("A count after clear", 32'(ifA.press_count), 0);
        applyStimulus(1'b0, 4'b0000);
        waitCycles(20);

        // Active-low instance: idle-high pins mean nothing is pressed.
        checkOutput("B idle level", 32'(ifB.key_level), 0);
        checkOutput("B idle count", 32'(ifB.press_count), 0);
        applyStimulus(1'b1, 4'b0001);
        waitCycles(20);
        checkOutput("B0 level after press", 32'(ifB.key_level), 4'b0001);
        checkOutput("B count after press", 32'(ifB.press_count), 1);

        // Reset mid-debounce of key 1 clears everything before the next edge.
        ifB.key_in[1] = 1'b0;
        waitCycles(8);
        #2 reset = 1'b1;
        #1;
        checkOutput("B async reset level", 32'(ifB.key_level), 0);
        checkOutput("B async reset press", 32'(ifB.key_press), 0);
        checkOutput("B async reset release", 32'(ifB.key_release), 0);
        checkOutput("B async reset count", 32'(ifB.press_count), 0);
        ifB.key_in[1] = 1'b1;
        waitCycles(3);
        reset     = 1'b0;
        expLevelB = 4'b0000;
        expCountB = 10'd0;
        expLevelA = 4'b0000;
        expCountA = 10'd0;
        applyStimulus(1'b1, 4'b0001);
        waitCycles(17);
        checkOutput("B0 level before re-accept", 32'(ifB.key_level[0]), 0);
        waitCycles(1);
        checkOutput("B0 level after re-accept", 32'(ifB.key_level[0]), 1);
        waitCycles(10);

        checkOutput("A expected pulses outstanding", qA.size(), 0);
        checkOutput("B expected pulses outstanding", qB.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
